ble_rx_byte_buffer: RTL and testbench

- Elastic byte buffer between the UART RX core and connection_monitor.
- Absorbs BLE module bursts ("OK+CONN:XXXXXXXXXXXX\r\n") that arrive faster than the monitor consumes them.
- Presents bytes through the monitor's existing valid / get / ready handshake.
- Drops frame-errored bytes and records overflow statistics for debug readout.

---
 rtl/ble_uart_pkg.sv | 24 ++
 rtl/ble_rx_fifo_mem.sv | 39 +++
 rtl/ble_rx_byte_buffer.sv | 138 +++++++++++++
 tb/tb_ble_rx_byte_buffer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ble_uart_pkg.sv
// Shared constants and types for the BLE UART receive path.
// Also used by connection_monitor and the special-register readout.
package ble_uart_pkg;

    localparam int BLE_RX_DEPTH = 16;

    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    typedef struct packed {
        logic       overflow;
        logic [7:0] drop_count;
    } rx_status_t;

    typedef enum logic {
        BUF_EMPTY    = 1'b0,
        BUF_NONEMPTY = 1'b1
    } buf_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/ble_rx_fifo_mem.sv
// DEPTH x 8 storage for the RX byte buffer: one synchronous write port and
// one registered read port whose output holds between reads.
module ble_rx_fifo_mem
    import ble_uart_pkg::*;
#(
    parameter int DEPTH = BLE_RX_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [PTR_W-1:0] wr_addr_i,
    input  logic [7:0]       wr_data_i,
    input  logic             rd_en_i,
    input  logic [PTR_W-1:0] rd_addr_i,
    output logic [7:0]       rd_data_o
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read-before-write: a full-buffer push/pop pair on the same slot returns the old byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ble_rx_byte_buffer.sv
// Elastic byte FIFO between the UART RX core and connection_monitor, with
// frame-error/overflow drop statistics and a one-cycle-latency pop handshake.
module ble_rx_byte_buffer
    import ble_uart_pkg::*;
#(
    parameter int DEPTH = BLE_RX_DEPTH,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_strobe,
    input  logic             rx_frame_err,
    input  logic             flush,
    input  logic             clear_status,
    input  logic             get_ack_byte,
    output logic [7:0]       ack_byte,
    output logic             ack_valid,
    output logic             ack_ready,
    output logic [CNT_W-1:0] fill_level,
    output logic             overflow,
    output logic [7:0]       drop_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    buf_state_t       state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ack_ready_q, ack_ready_d;
    rx_status_t       status_q, status_d;

    logic is_full;
    logic clean_byte;
    logic pop_accept;
    logic push_accept;
    logic full_drop;
    logic any_drop;

    assign is_full     = (count_q == FULL_CNT);
    assign clean_byte  = rx_strobe && !rx_frame_err;
    assign pop_accept  = get_ack_byte && (state_q == BUF_NONEMPTY) && !flush;
    assign push_accept = clean_byte && !flush && (!is_full || pop_accept);
    assign full_drop   = clean_byte && !flush && is_full && !pop_accept;
    assign any_drop    = (rx_strobe && rx_frame_err) || full_drop;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        state_d     = state_q;
        ack_ready_d = pop_accept;
        status_d    = status_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_accept) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_accept) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push_accept, pop_accept})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        case (state_q)
            BUF_EMPTY: begin
                if (push_accept) begin
                    state_d = BUF_NONEMPTY;
                end
            end
            BUF_NONEMPTY: begin
                if (flush || (pop_accept && !push_accept && count_q == CNT_W'(1))) begin
                    state_d = BUF_EMPTY;
                end
            end
            default: state_d = BUF_EMPTY;
        endcase

        // A drop in the same cycle as clear_status survives as a fresh count of one.
        if (clear_status) begin
            status_d = '0;
        end
        if (any_drop) begin
            status_d.drop_count = clear_status ? 8'd1 : sat_inc8(status_q.drop_count);
            if (full_drop) begin
                status_d.overflow = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= BUF_EMPTY;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ack_ready_q <= 1'b0;
            status_q    <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ack_ready_q <= ack_ready_d;
            status_q    <= status_d;
        end
    end

    ble_rx_fifo_mem #(
        .DEPTH(DEPTH)
    ) u_mem (
        .clk      (clk),
        .rst      (rst),
        .wr_en_i  (push_accept),
        .wr_addr_i(wr_ptr_q),
        .wr_data_i(rx_data),
        .rd_en_i  (pop_accept),
        .rd_addr_i(rd_ptr_q),
        .rd_data_o(ack_byte)
    );

    assign ack_valid  = (count_q != '0);
    assign ack_ready  = ack_ready_q;
    assign fill_level = count_q;
    assign overflow   = status_q.overflow;
    assign drop_count = status_q.drop_count;

endmodule

// File: tb/tb_ble_rx_byte_buffer.sv
// Scoreboard bench for ble_rx_byte_buffer: a queue model tracks accepted bytes
// and drop statistics, and each scenario task compares DUT outputs against it.
module tb_ble_rx_byte_buffer;

    localparam int DEPTH = 16;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       rx_data;
    logic             rx_strobe;
    logic             rx_frame_err;
    logic             flush;
    logic             clear_status;
    logic             get_ack_byte;
    logic [7:0]       ack_byte;
    logic             ack_valid;
    logic             ack_ready;
    logic [CNT_W-1:0] fill_level;
    logic             overflow;
    logic [7:0]       drop_count;

    int checks = 0;
    int errors = 0;

    logic [7:0] sbQ [$];
    logic       expReady;
    logic [7:0] expByte;
    logic       expOverflow;
    logic [7:0] expDrops;

    always #5 clk = ~clk;

    ble_rx_byte_buffer #(
        .DEPTH(DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_strobe   (rx_strobe),
        .rx_frame_err(rx_frame_err),
        .flush       (flush),
        .clear_status(clear_status),
        .get_ack_byte(get_ack_byte),
        .ack_byte    (ack_byte),
        .ack_valid   (ack_valid),
        .ack_ready   (ack_ready),
        .fill_level  (fill_level),
        .overflow    (overflow),
        .drop_count  (drop_count)
    );

    // Drives one cycle of stimulus, advances the scoreboard, and returns 1ns after the edge.
    task automatic step(input logic s, input logic [7:0] d, input logic fe,
                        input logic g, input logic fl, input logic cl);
        logic popOk, clean, pushOk, fullDrop;
        popOk    = g && (sbQ.size() > 0) && !fl;
        clean    = s && !fe;
        pushOk   = clean && !fl && ((sbQ.size() < DEPTH) || popOk);
        fullDrop = clean && !fl && (sbQ.size() == DEPTH) && !popOk;
        rx_strobe = s; rx_data = d; rx_frame_err = fe;
        get_ack_byte = g; flush = fl; clear_status = cl;
        @(posedge clk);
        #1;
        rx_strobe = 0; rx_data = 0; rx_frame_err = 0;
        get_ack_byte = 0; flush = 0; clear_status = 0;
        expReady = popOk;
        if (fl) begin
            sbQ.delete();
        end else begin
            if (popOk) expByte = sbQ.pop_front();
            if (pushOk) sbQ.push_back(d);
        end
        if (s && (fe || fullDrop)) begin
            expDrops = cl ? 8'd1 : ((expDrops == 8'hFF) ? 8'hFF : expDrops + 8'd1);
            if (fullDrop) expOverflow = 1'b1;
            else if (cl) expOverflow = 1'b0;
        end else if (cl) begin
            expDrops = 8'd0;
            expOverflow = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx_strobe = 0; rx_data = 0; rx_frame_err = 0;
        get_ack_byte = 0; flush = 0; clear_status = 0;
        sbQ.delete(); expReady = 0; expByte = 0; expOverflow = 0; expDrops = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({ack_byte, ack_valid, ack_ready, fill_level, overflow, drop_count} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got byte=%h v=%b r=%b fill=%0d ovf=%b drops=%0d want all zero",
                     ack_byte, ack_valid, ack_ready, fill_level, overflow, drop_count);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step(1, 8'h60 + 8'(i), 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(1, 8'h70, 1, 0, 0, 0);
        checks++;
        if (fill_level !== CNT_W'(4)) begin
            errors++;
            $display("[TB] FAIL pre_reset_fill: got %0d want 4", fill_level);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({ack_byte, ack_valid, ack_ready, fill_level, overflow, drop_count} !== '0) begin
            errors++;
            $display("[TB] FAIL async_reset: got byte=%h v=%b r=%b fill=%0d ovf=%b drops=%0d want all zero",
                     ack_byte, ack_valid, ack_ready, fill_level, overflow, drop_count);
        end
        sbQ.delete(); expReady = 0; expByte = 0; expOverflow = 0; expDrops = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(0, 0, 0, 1, 0, 0);
        checks++;
        if (ack_ready !== 1'b0 || ack_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL empty_get_after_reset: got ready=%b valid=%b want 0 0", ack_ready, ack_valid);
        end
    endtask

    task automatic test_single();
        step(1, 8'h4F, 0, 0, 0, 0);
        checks++;
        if (ack_valid !== 1'b1 || fill_level !== CNT_W'(1)) begin
            errors++;
            $display("[TB] FAIL single_push: got valid=%b fill=%0d want 1 1", ack_valid, fill_level);
        end
        step(0, 0, 0, 1, 0, 0);
        checks++;
        if (ack_ready !== 1'b1 || ack_byte !== 8'h4F || expByte !== 8'h4F) begin
            errors++;
            $display("[TB] FAIL single_pop: got ready=%b byte=%h want 1 4f", ack_ready, ack_byte);
        end
        checks++;
        if (ack_valid !== 1'b0 || fill_level !== CNT_W'(0)) begin
            errors++;
            $display("[TB] FAIL single_empty: got valid=%b fill=%0d want 0 0", ack_valid, fill_level);
        end
        step(0, 0, 0, 0, 0, 0);
        checks++;
        if (ack_ready !== 1'b0 || ack_byte !== 8'h4F) begin
            errors++;
            $display("[TB] FAIL single_hold: got ready=%b byte=%h want 0 4f", ack_ready, ack_byte);
        end
    endtask

    task automatic test_burst();
        logic [7:0] burst [7];
        burst = '{8'h4F, 8'h4B, 8'h2B, 8'h43, 8'h4F, 8'h4E, 8'h4E};
        for (int i = 0; i < 7; i++) step(1, burst[i], 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            step(0, 0, 0, 1, 0, 0);
            checks++;
            if (ack_ready !== 1'b1 || ack_byte !== expByte || ack_byte !== burst[i]) begin
                errors++;
                $display("[TB] FAIL burst_pop%0d: got ready=%b byte=%h want 1 %h", i, ack_ready, ack_byte, burst[i]);
            end
        end
        checks++;
        if (fill_level !== CNT_W'(0)) begin
            errors++;
            $display("[TB] FAIL burst_fill: got %0d want 0", fill_level);
        end
    endtask

    task automatic test_full_wrap();
        logic [7:0] want;
        for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0, 0, 0);
        step(1, 8'hAA, 0, 0, 0, 0);
        checks++;
        if (overflow !== 1'b1 || drop_count !== 8'd1 || fill_level !== CNT_W'(16)) begin
            errors++;
            $display("[TB] FAIL full_drop: got ovf=%b drops=%0d fill=%0d want 1 1 16", overflow, drop_count, fill_level);
        end
        step(1, 8'hBB, 0, 1, 0, 0);
        checks++;
        if (ack_ready !== 1'b1 || ack_byte !== 8'h00 || fill_level !== CNT_W'(16) || drop_count !== expDrops) begin
            errors++;
            $display("[TB] FAIL full_push_pop: got ready=%b byte=%h fill=%0d drops=%0d want 1 00 16 %0d",
                     ack_ready, ack_byte, fill_level, drop_count, expDrops);
        end
        for (int i = 0; i < 16; i++) begin
            want = (i < 15) ? 8'(i + 1) : 8'hBB;
            step(0, 0, 0, 1, 0, 0);
            checks++;
            if (ack_ready !== 1'b1 || ack_byte !== expByte || ack_byte !== want) begin
                errors++;
                $display("[TB] FAIL drain%0d: got ready=%b byte=%h want 1 %h", i, ack_ready, ack_byte, want);
            end
        end
        checks++;
        if (fill_level !== CNT_W'(0) || ack_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drain_empty: got fill=%0d valid=%b want 0 0", fill_level, ack_valid);
        end
    endtask

    task automatic test_frame_err();
        step(0, 0, 0, 0, 0, 1);
        step(1, 8'h41, 1, 0, 0, 0);
        checks++;
        if (drop_count !== 8'd1 || overflow !== 1'b0 || fill_level !== CNT_W'(0)) begin
            errors++;
            $display("[TB] FAIL frame_err: got drops=%0d ovf=%b fill=%0d want 1 0 0", drop_count, overflow, fill_level);
        end
        for (int i = 0; i < 300; i++) step(1, 8'(i), 1, 0, 0, 0);
        checks++;
        if (drop_count !== 8'hFF || drop_count !== expDrops) begin
            errors++;
            $display("[TB] FAIL drop_saturate: got %0d want 255", drop_count);
        end
        step(1, 8'h42, 1, 0, 0, 1);
        checks++;
        if (drop_count !== 8'd1 || overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clear_with_drop: got drops=%0d ovf=%b want 1 0", drop_count, overflow);
        end
        step(0, 0, 0, 0, 0, 1);
        checks++;
        if (drop_count !== 8'd0 || overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clear_status: got drops=%0d ovf=%b want 0 0", drop_count, overflow);
        end
    endtask

    task automatic test_flush();
        step(1, 8'hA1, 0, 0, 0, 0);
        step(1, 8'hA2, 0, 0, 0, 0);
        step(1, 8'hA3, 0, 0, 0, 0);
        step(1, 8'h77, 0, 1, 1, 0);
        checks++;
        if (fill_level !== CNT_W'(0) || ack_ready !== 1'b0 || ack_valid !== 1'b0 || drop_count !== expDrops) begin
            errors++;
            $display("[TB] FAIL flush: got fill=%0d ready=%b valid=%b drops=%0d want 0 0 0 %0d",
                     fill_level, ack_ready, ack_valid, drop_count, expDrops);
        end
        step(0, 0, 0, 1, 0, 0);
        checks++;
        if (ack_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_empty_get: got ready=%b want 0", ack_ready);
        end
        step(1, 8'h3A, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        checks++;
        if (ack_ready !== 1'b1 || ack_byte !== 8'h3A || ack_byte !== expByte) begin
            errors++;
            $display("[TB] FAIL post_flush_byte: got ready=%b byte=%h want 1 3a", ack_ready, ack_byte);
        end
    endtask

    task automatic test_back_to_back();
        step(1, 8'(($urandom)), 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            step(1, 8'(($urandom)), 0, 1, 0, 0);
            checks++;
            if (ack_ready !== 1'b1 || ack_byte !== expByte || fill_level !== CNT_W'(sbQ.size())) begin
                errors++;
                $display("[TB] FAIL b2b%0d: got ready=%b byte=%h fill=%0d want 1 %h %0d",
                         i, ack_ready, ack_byte, fill_level, expByte, sbQ.size());
            end
        end
        step(0, 0, 0, 1, 0, 0);
        checks++;
        if (ack_ready !== expReady || ack_byte !== expByte || fill_level !== CNT_W'(0)) begin
            errors++;
            $display("[TB] FAIL b2b_last: got ready=%b byte=%h fill=%0d want 1 %h 0", ack_ready, ack_byte, fill_level, expByte);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_full_wrap();
        test_frame_err();
        test_flush();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
